// File: rtl/filter_pair_buffer_pkg.sv
// Shared definitions for the filter pair buffer and the downstream force
// pipeline: coordinate/pair widths, in_data field offsets, FSM encoding.
package filter_pair_buffer_pkg;

  localparam int CELL_ID_WIDTH = 3;
  localparam int BODY_BITS     = 8;
  localparam int PID_WIDTH     = 9;
  localparam int COORD_W       = CELL_ID_WIDTH + BODY_BITS;

  function automatic int pair_width(input int pid_w, input int coord_w);
    return 2 * pid_w + 6 * coord_w;
  endfunction

  localparam int PAIR_W = pair_width(PID_WIDTH, COORD_W);

  // in_data = {home_pid, nb_pid, x1, y1, z1, x2, y2, z2}, z2 in the LSBs
  localparam int Z2_LSB       = 0;
  localparam int Y2_LSB       = 1 * COORD_W;
  localparam int X2_LSB       = 2 * COORD_W;
  localparam int Z1_LSB       = 3 * COORD_W;
  localparam int Y1_LSB       = 4 * COORD_W;
  localparam int X1_LSB       = 5 * COORD_W;
  localparam int NB_PID_LSB   = 6 * COORD_W;
  localparam int HOME_PID_LSB = NB_PID_LSB + PID_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/filter_pair_buffer_if.sv
// Bus between pair generator / range filter, the pair buffer, and the force
// pipeline. Optional statistics outputs exist when FILTER_STATS_EN is defined.
interface filter_pair_buffer_if;
  import filter_pair_buffer_pkg::*;

  logic              in_valid;
  logic              in_pass;
  logic              in_last;
  logic [PAIR_W-1:0] in_data;
  logic              stall;
  logic              out_valid;
  logic              out_ready;
  logic [PAIR_W-1:0] out_data;
  logic              overflow;
  logic              sweep_done;
`ifdef FILTER_STATS_EN
  logic [15:0]       stat_candidates;
  logic [15:0]       stat_passed;

  modport slave (
    input  in_valid, in_pass, in_last, in_data, out_ready,
    output stall, out_valid, out_data, overflow, sweep_done,
           stat_candidates, stat_passed
  );
  modport master (
    output in_valid, in_pass, in_last, in_data, out_ready,
    input  stall, out_valid, out_data, overflow, sweep_done,
           stat_candidates, stat_passed
  );
`else
  modport slave (
    input  in_valid, in_pass, in_last, in_data, out_ready,
    output stall, out_valid, out_data, overflow, sweep_done
  );
  modport master (
    output in_valid, in_pass, in_last, in_data, out_ready,
    input  stall, out_valid, out_data, overflow, sweep_done
  );
`endif
endinterface

// File: rtl/filter_pair_buffer_pair_fifo.sv
// pair_fifo: first-word fall-through FIFO. Pointers carry one extra wrap bit
// so full/empty come from the MSB compare; occupancy is kept as a register.
// Callers must only push when not full (or popping) and only pop when valid.
module pair_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [PW-1:0]     count_o,
  output logic [PW-1:0]     count_next_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              empty;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + PW'(push_i) - PW'(pop_i);
  end

  // Control state: pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; data is not reset, the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign valid_o      = !empty;
  assign rdata_o      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/filter_pair_buffer.sv
// filter_pair_buffer: queues filter-passing candidate pairs and drains them to
// the force pipeline; tracks sweep progress, back-pressure and drops.
// Optional build macro: FILTER_STATS_EN adds candidate/passed counters.
module filter_pair_buffer
  import filter_pair_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input logic                 clk,
  input logic                 rst,
  filter_pair_buffer_if.slave bus
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

  fsm_state_e        state_q, state_d;
  logic              stall_q, stall_d;
  logic              overflow_q, overflow_d;
  logic              accepting, push, pop, drop, proto_err;
  logic              fifo_full, fifo_valid;
  logic [CW-1:0]     count, count_next;
  logic [PAIR_W-1:0] head;

  // Candidates are only taken before the sweep's last one has been seen
  assign accepting = (state_q == IDLE) || (state_q == ACTIVE);
  assign pop       = fifo_valid && bus.out_ready;
  assign push      = bus.in_valid && bus.in_pass && accepting && (!fifo_full || pop);
  assign drop      = bus.in_valid && bus.in_pass && accepting && fifo_full && !pop;
  assign proto_err = bus.in_valid && !accepting;

  pair_fifo #(
    .DATA_W (PAIR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (bus.in_data),
    .rdata_o      (head),
    .valid_o      (fifo_valid),
    .full_o       (fifo_full),
    .count_o      (count),
    .count_next_o (count_next)
  );

  // Sweep FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.in_valid) state_d = bus.in_last ? DRAIN : ACTIVE;
      ACTIVE: if (bus.in_valid && bus.in_last) state_d = DRAIN;
      DRAIN:  if ((count == '0) && !push) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase
  end

  // Almost-full lookahead and sticky drop/protocol-error flag
  always_comb begin
    stall_d    = (count_next >= AF_LEVEL);
    overflow_d = overflow_q | drop | proto_err;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.stall      = stall_q;
  assign bus.out_valid  = fifo_valid;
  assign bus.out_data   = head;
  assign bus.overflow   = overflow_q;
  assign bus.sweep_done = (state_q == DONE);

`ifdef FILTER_STATS_EN
  logic [15:0] cand_q, cand_d;
  logic [15:0] passed_q, passed_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Statistics next state; a new sweep restarts counting with its first candidate
  always_comb begin
    cand_d   = sat_inc(cand_q, bus.in_valid);
    passed_d = sat_inc(passed_q, push);
    if ((state_q == IDLE) && (state_d == ACTIVE)) begin
      cand_d   = 16'd1;
      passed_d = {15'd0, push};
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q   <= '0;
      passed_q <= '0;
    end else begin
      cand_q   <= cand_d;
      passed_q <= passed_d;
    end
  end

  assign bus.stat_candidates = cand_q;
  assign bus.stat_passed     = passed_q;
`endif

endmodule

// File: tb/tb_filter_pair_buffer.sv
// Directed self-checking bench for filter_pair_buffer (DEPTH=8, AF_MARGIN=2).
module tb_filter_pair_buffer;
  import filter_pair_buffer_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  filter_pair_buffer_if bus();

  filter_pair_buffer #(.DEPTH(8), .AF_MARGIN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PAIR_W-1:0] mk_pair(input int k);
    logic [PAIR_W-1:0] p;
    p = '0;
    p[HOME_PID_LSB +: PID_WIDTH] = PID_WIDTH'(k + 1);
    p[NB_PID_LSB +: PID_WIDTH]   = PID_WIDTH'(k + 300);
    p[X1_LSB +: COORD_W]         = COORD_W'(k * 37 + 5);
    p[Y2_LSB +: COORD_W]         = COORD_W'(k * 101 + 9);
    p[Z2_LSB +: COORD_W]         = COORD_W'(2000 - k * 11);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic p, input logic l, input logic [PAIR_W-1:0] d);
    bus.in_valid = v;
    bus.in_pass  = p;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_done: got %b expected 0", bus.sweep_done); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
    rst = 1'b1;
  endtask

  task automatic test_push3();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, mk_pair(k));
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL push3_valid[%0d]: got %b expected 1", k, bus.out_valid); end
      n_checks++; if (bus.out_data !== mk_pair(k)) begin n_fail++; $display("FAIL push3_data[%0d]: got %h expected %h", k, bus.out_data, mk_pair(k)); end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL push3_empty: got %b expected 0", bus.out_valid); end
    n_checks++; if (int'(dut.u_fifo.count_q) !== 0) begin n_fail++; $display("FAIL push3_count: got %0d expected 0", dut.u_fifo.count_q); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, mk_pair(k));
      tick();
      n_checks++; if (bus.stall !== (k >= 5)) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b expected %b", k, bus.stall, (k >= 5)); end
      n_checks++; if (bus.overflow !== (k >= 8)) begin n_fail++; $display("FAIL fill_overflow[%0d]: got %b expected %b", k, bus.overflow, (k >= 8)); end
      n_checks++; if (bus.out_data !== mk_pair(0)) begin n_fail++; $display("FAIL fill_head[%0d]: got %h expected %h", k, bus.out_data, mk_pair(0)); end
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (int'(dut.u_fifo.count_q) !== 8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", dut.u_fifo.count_q); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (bus.out_data !== mk_pair(k) || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_drain[%0d]: got %h valid %b expected %h", k, bus.out_data, bus.out_valid, mk_pair(k)); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, mk_pair(k));
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, mk_pair(8));
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b0;
    n_checks++; if (int'(dut.u_fifo.count_q) !== 8) begin n_fail++; $display("FAIL fullpp_count: got %0d expected 8", dut.u_fifo.count_q); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.out_data !== mk_pair(1)) begin n_fail++; $display("FAIL fullpp_head: got %h expected %h", bus.out_data, mk_pair(1)); end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      n_checks++; if (bus.out_data !== mk_pair(k)) begin n_fail++; $display("FAIL fullpp_drain[%0d]: got %h expected %h", k, bus.out_data, mk_pair(k)); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_alternate_pass();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k % 2) == 0, 1'b0, mk_pair(k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (int'(dut.u_fifo.count_q) !== 3) begin n_fail++; $display("FAIL alt_count: got %0d expected 3", dut.u_fifo.count_q); end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (bus.out_data !== mk_pair(2 * j)) begin n_fail++; $display("FAIL alt_data[%0d]: got %h expected %h", j, bus.out_data, mk_pair(2 * j)); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL alt_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_sweep_done();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, mk_pair(k));
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, mk_pair(2));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (dut.state_q !== DRAIN) begin n_fail++; $display("FAIL sweep_state_drain: got %0d expected %0d", dut.state_q, DRAIN); end
    n_checks++; if (int'(dut.u_fifo.count_q) !== 2) begin n_fail++; $display("FAIL sweep_count2: got %0d expected 2", dut.u_fifo.count_q); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL sweep_early[%0d]: got %b expected 0", c, bus.sweep_done); end
      tick();
    end
    n_checks++; if (int'(dut.u_fifo.count_q) !== 0 || bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL sweep_at_empty: count %0d done %b expected 0 0", dut.u_fifo.count_q, bus.sweep_done); end
    tick();
    n_checks++; if (bus.sweep_done !== 1'b1) begin n_fail++; $display("FAIL sweep_pulse: got %b expected 1", bus.sweep_done); end
    tick();
    n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL sweep_pulse_end: got %b expected 0", bus.sweep_done); end
    drive(1'b1, 1'b1, 1'b0, mk_pair(5));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (dut.state_q !== ACTIVE) begin n_fail++; $display("FAIL sweep_reactivate: got %0d expected %0d", dut.state_q, ACTIVE); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL sweep_overflow: got %b expected 0", bus.overflow); end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk_pair(5)) begin n_fail++; $display("FAIL sweep_new_head: got %h valid %b expected %h", bus.out_data, bus.out_valid, mk_pair(5)); end
  endtask

  task automatic test_protocol_error();
    apply_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, mk_pair(0));
    tick();
    n_checks++; if (dut.state_q !== DRAIN || int'(dut.u_fifo.count_q) !== 1) begin n_fail++; $display("FAIL single_sweep: state %0d count %0d expected %0d 1", dut.state_q, dut.u_fifo.count_q, DRAIN); end
    drive(1'b1, 1'b1, 1'b0, mk_pair(1));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL proto_overflow: got %b expected 1", bus.overflow); end
    n_checks++; if (int'(dut.u_fifo.count_q) !== 1) begin n_fail++; $display("FAIL proto_ignored: got %0d expected 1", dut.u_fifo.count_q); end
    bus.out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.sweep_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", bus.sweep_done); end
  endtask

  task automatic test_reset_mid_sweep();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, mk_pair(k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", bus.out_data); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_done[%0d]: got %b expected 0", c, bus.sweep_done); end
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || int'(dut.u_fifo.count_q) !== 0) begin n_fail++; $display("FAIL mid_post_empty: valid %b count %0d expected 0 0", bus.out_valid, dut.u_fifo.count_q); end
    n_checks++; if (bus.sweep_done !== 1'b0) begin n_fail++; $display("FAIL mid_post_done: got %b expected 0", bus.sweep_done); end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    bus.out_ready = 1'b0;
    test_reset();
    test_push3();
    test_fill_overflow();
    test_full_push_pop();
    test_alternate_pass();
    test_sweep_done();
    test_protocol_error();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
